alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage that converts a 32-bit RV32I instruction into the control bundle consumed by the core's ALU and EX stage. It emits an `ALUOP_WIDTH` op code from `alu_ops.vh`, operand selects, the sign-extended immediate, and register-write info. It sits between fetch and EX and uses a valid/ready handshake on both sides. A one-entry skid buffer lets it run at full throughput under backpressure.

## Interface
- `DWIDTH`, 32, data and PC width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered, equals `!skid_valid`.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  DWIDTH  instruction PC.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  output bundle valid.
- `out_ready`  in  1  EX accepts the bundle.
- `out_alu_op`  out  `ALUOP_WIDTH`  one of the `ALU_*` codes.
- `out_a_sel`  out  1  0 = rs1, 1 = PC.
- `out_b_sel`  out  1  0 = rs2, 1 = immediate.
- `out_imm`  out  DWIDTH  sign-extended immediate.
- `out_pc`  out  DWIDTH  PC of the instruction.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices from `inst[19:15]`, `[24:20]`, `[11:7]`.
- `out_reg_we`  out  1  destination write enable.
- `out_illegal`  out  1  opcode or funct not decodable.

## Operation
- Decode by opcode `inst[6:0]`:
  - OP (0x33): a = rs1, b = rs2.
    - funct7 = 0x00: funct3 maps to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - funct7 = 0x20: only SUB (f3 = 0) or SRA (f3 = 5); any other combination is illegal.
  - OP-IMM (0x13): a = rs1, b = I-imm, same funct3 map.
    - Shifts: `inst[31:25]` must be 0x00; 0x20 is allowed only for SRAI. Anything else is illegal.
    - Non-shifts ignore `inst[31:25]`.
  - LUI (0x37): `ALU_B`, b = U-imm.
  - AUIPC (0x17): `ALU_ADD`, a = PC, b = U-imm.
  - LOAD (0x03): `ALU_ADD`, a = rs1, b = I-imm, `reg_we` = 1.
  - STORE (0x23): `ALU_ADD`, a = rs1, b = S-imm, `reg_we` = 0.
  - JAL (0x6F): `ALU_ADD`, a = PC, b = J-imm, `reg_we` = 1.
  - JALR (0x67, f3 = 0): `ALU_ADD`, a = rs1, b = I-imm, `reg_we` = 1.
  - BRANCH (0x63): `ALU_ADD`, a = PC, b = B-imm, `reg_we` = 0.
  - Any other opcode: `out_illegal` = 1, `ALU_ADD`, selects 0, `reg_we` = 0, `imm` = 0.
- `reg_we` = 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL and JALR, and is forced to 0 when rd = 0.
- Immediates are sign-extended from `inst[31]`. U-imm is `{inst[31:12], 12'b0}`.
- Handshake storage consists of an output register plus one skid entry.
  - Accept occurs when `in_valid && in_ready`.
  - On accept:
    - If the output is empty, or `out_ready` is high and the skid is empty, the decoded bundle loads into the output register.
    - Otherwise it loads into the skid and `in_ready` falls next cycle.
  - When `out_valid && out_ready` and the skid is full, the skid moves to the output and `in_ready` rises next cycle.
  - When `out_valid && out_ready`, the skid is empty and there is no accept, `out_valid` falls.
- Output fields are stable whenever `out_valid && !out_ready`.
- Ordering is strict FIFO: no loss, no duplication.
- `flush` has priority over everything:
  - At the next edge, `out_valid` = 0 and the skid is emptied.
  - An instruction accepted in the flush cycle is dropped.
  - `in_ready` = 1 in the following cycle.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N has `out_valid` high after edge N.
- Throughput is 1 instruction/cycle while `out_ready` is held high.
- `in_ready` is a register output with no combinational path from `out_ready`.
- Reset values, applied immediately and asynchronously:
  - `out_valid` = 0, skid empty, `in_ready` = 1.
  - All output fields 0, `out_alu_op` = `ALU_ADD`.
- Reset asserted mid-stream discards both entries. The first accept after deassertion is taken at the first rising edge with `rst` low.

## Test plan
- `in_inst` = 0x002081B3 (add x3,x1,x2) -> next cycle: `ALU_ADD`, a_sel = 0, b_sel = 0, rs1 = 1, rs2 = 2, rd = 3, reg_we = 1, illegal = 0.
- Back-to-back 0x407302B3 (sub x5,x6,x7), then 0x40315093 (srai x1,x2,3), then 0x12345537 (lui x10,0x12345), with `out_ready` = 1 -> consecutive cycles show:
  - `ALU_SUB`;
  - `ALU_SRA` with b_sel = 1, imm = 3;
  - `ALU_B` with imm = 0x12345000.
- 0xFE000EE3 (beq x0,x0,-4) at `in_pc` = 0x100 -> `ALU_ADD`, a_sel = 1, b_sel = 1, imm = 0xFFFFFFFC, out_pc = 0x100, reg_we = 0.
- 0x00000000 -> illegal = 1, reg_we = 0. 0x00000033 (add x0,x0,x0) -> reg_we = 0, illegal = 0.
- Backpressure:
  - Hold `out_ready` = 0 and offer I0, I1, I2 back-to-back -> I0 in output, I1 in skid, `in_ready` = 0 from the cycle after I1 is accepted, I2 not accepted.
  - Then set `out_ready` = 1 -> I0, I1, I2 emerge in order, each exactly once.
- Flush and reset:
  - Fill both entries and pulse `flush` with `in_valid` = 1 -> next cycle `out_valid` = 0 and `in_ready` = 1, and the offered instruction never appears.
  - Repeat with `rst` pulsed mid-cycle -> outputs go to reset values before the next edge.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns an instruction word into the ALU/EX control bundle.
// An output register plus one skid entry give full throughput behind a registered in_ready.
module alu_decode_stage #(
    parameter  int unsigned DWIDTH      = 32,
    localparam int unsigned ALUOP_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [DWIDTH-1:0]      in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALUOP_WIDTH-1:0] out_alu_op,
    output logic                   out_a_sel,
    output logic                   out_b_sel,
    output logic [DWIDTH-1:0]      out_imm,
    output logic [DWIDTH-1:0]      out_pc,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic                   out_reg_we,
    output logic                   out_illegal
);

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 4'd9;
    localparam logic [ALUOP_WIDTH-1:0] ALU_B    = 4'd10;

    typedef struct packed {
        logic [ALUOP_WIDTH-1:0] alu_op;
        logic                   a_sel;
        logic                   b_sel;
        logic [DWIDTH-1:0]      imm;
        logic [DWIDTH-1:0]      pc;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic                   reg_we;
        logic                   illegal;
    } bundle_t;

    logic [6:0]             w_opcode;
    logic [2:0]             w_f3;
    logic [6:0]             w_f7;
    logic [ALUOP_WIDTH-1:0] w_f3_op;
    logic [DWIDTH-1:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    bundle_t                w_dec;

    bundle_t r_out;
    bundle_t r_skid;
    logic    r_out_valid;
    logic    r_skid_valid;
    logic    r_in_ready;

    logic w_accept;
    logic w_out_fire;

    assign w_opcode = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign w_f7     = in_inst[31:25];

    assign w_imm_i  = {{(DWIDTH-12){in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s  = {{(DWIDTH-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b  = {{(DWIDTH-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u  = {{(DWIDTH-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign w_imm_j  = {{(DWIDTH-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    // Shift-immediates carry only the shift amount; inst[31:25] is funct7 there.
    assign w_imm_sh = {{(DWIDTH-5){1'b0}}, in_inst[24:20]};

    always_comb begin
        w_f3_op = ALU_ADD;
        case (w_f3)
            3'd0: w_f3_op = ALU_ADD;
            3'd1: w_f3_op = ALU_SLL;
            3'd2: w_f3_op = ALU_SLT;
            3'd3: w_f3_op = ALU_SLTU;
            3'd4: w_f3_op = ALU_XOR;
            3'd5: w_f3_op = ALU_SRL;
            3'd6: w_f3_op = ALU_OR;
            3'd7: w_f3_op = ALU_AND;
            default: w_f3_op = ALU_ADD;
        endcase
    end

    always_comb begin
        w_dec        = '0;
        w_dec.alu_op = ALU_ADD;
        w_dec.pc     = in_pc;
        w_dec.rs1    = in_inst[19:15];
        w_dec.rs2    = in_inst[24:20];
        w_dec.rd     = in_inst[11:7];
        case (w_opcode)
            7'h33: begin
                w_dec.reg_we = 1'b1;
                if (w_f7 == 7'h00)                       w_dec.alu_op = w_f3_op;
                else if (w_f7 == 7'h20 && w_f3 == 3'd0)  w_dec.alu_op = ALU_SUB;
                else if (w_f7 == 7'h20 && w_f3 == 3'd5)  w_dec.alu_op = ALU_SRA;
                else                                     w_dec.illegal = 1'b1;
            end
            7'h13: begin
                w_dec.reg_we = 1'b1;
                w_dec.b_sel  = 1'b1;
                w_dec.alu_op = w_f3_op;
                w_dec.imm    = w_imm_i;
                if (w_f3 == 3'd1) begin
                    w_dec.imm = w_imm_sh;
                    if (w_f7 != 7'h00) w_dec.illegal = 1'b1;
                end else if (w_f3 == 3'd5) begin
                    w_dec.imm = w_imm_sh;
                    if (w_f7 == 7'h20)      w_dec.alu_op  = ALU_SRA;
                    else if (w_f7 != 7'h00) w_dec.illegal = 1'b1;
                end
            end
            7'h37: begin
                w_dec.alu_op = ALU_B;
                w_dec.b_sel  = 1'b1;
                w_dec.imm    = w_imm_u;
                w_dec.reg_we = 1'b1;
            end
            7'h17: begin
                w_dec.a_sel  = 1'b1;
                w_dec.b_sel  = 1'b1;
                w_dec.imm    = w_imm_u;
                w_dec.reg_we = 1'b1;
            end
            7'h03: begin
                w_dec.b_sel  = 1'b1;
                w_dec.imm    = w_imm_i;
                w_dec.reg_we = 1'b1;
            end
            7'h23: begin
                w_dec.b_sel = 1'b1;
                w_dec.imm   = w_imm_s;
            end
            7'h6F: begin
                w_dec.a_sel  = 1'b1;
                w_dec.b_sel  = 1'b1;
                w_dec.imm    = w_imm_j;
                w_dec.reg_we = 1'b1;
            end
            7'h67: begin
                w_dec.b_sel   = 1'b1;
                w_dec.imm     = w_imm_i;
                w_dec.reg_we  = 1'b1;
                w_dec.illegal = (w_f3 != 3'd0);
            end
            7'h63: begin
                w_dec.a_sel = 1'b1;
                w_dec.b_sel = 1'b1;
                w_dec.imm   = w_imm_b;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // Undecodable words collapse to a harmless ADD with no side effects.
        if (w_dec.illegal) begin
            w_dec.alu_op = ALU_ADD;
            w_dec.a_sel  = 1'b0;
            w_dec.b_sel  = 1'b0;
            w_dec.imm    = '0;
            w_dec.reg_we = 1'b0;
        end
        if (w_dec.rd == 5'd0) w_dec.reg_we = 1'b0;
    end

    assign w_accept   = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Output register + skid entry; in_ready mirrors skid emptiness one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_fire && r_skid_valid) begin
            r_out        <= r_skid;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_accept) begin
            if (!r_out_valid || out_ready) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_alu_op  = r_out.alu_op;
    assign out_a_sel   = r_out.a_sel;
    assign out_b_sel   = r_out.b_sel;
    assign out_imm     = r_out.imm;
    assign out_pc      = r_out.pc;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_rd      = r_out.rd;
    assign out_reg_we  = r_out.reg_we;
    assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage: decode vectors, backpressure, flush and reset.
module tb_alu_decode_stage;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_B   = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_alu_op;
    logic        out_a_sel;
    logic        out_b_sel;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_decode_stage #(.DWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_op (out_alu_op),
        .out_a_sel  (out_a_sel),
        .out_b_sel  (out_b_sel),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_reg_we (out_reg_we),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle a little after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bundle(input string tag, input logic [3:0] op, input logic a_sel,
                                input logic b_sel, input logic [31:0] imm, input logic we,
                                input logic ill);
        check({tag, ".valid"},   64'(out_valid),   64'd1);
        check({tag, ".op"},      64'(out_alu_op),  64'(op));
        check({tag, ".a_sel"},   64'(out_a_sel),   64'(a_sel));
        check({tag, ".b_sel"},   64'(out_b_sel),   64'(b_sel));
        check({tag, ".imm"},     64'(out_imm),     64'(imm));
        check({tag, ".reg_we"},  64'(out_reg_we),  64'(we));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst.out_valid", 64'(out_valid),  64'd0);
        check("rst.in_ready",  64'(in_ready),   64'd1);
        check("rst.alu_op",    64'(out_alu_op), 64'(ALU_ADD));
        check("rst.imm",       64'(out_imm),    64'd0);
        check("rst.pc",        64'(out_pc),     64'd0);
        check("rst.reg_we",    64'(out_reg_we), 64'd0);
        step();
        rst = 1'b0;

        // add x3,x1,x2
        offer(32'h002081B3, 32'h40);
        step();
        in_valid = 1'b0;
        check_bundle("add", ALU_ADD, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("add.rs1", 64'(out_rs1), 64'd1);
        check("add.rs2", 64'(out_rs2), 64'd2);
        check("add.rd",  64'(out_rd),  64'd3);
        check("add.pc",  64'(out_pc),  64'h40);
        step();
        check("add.drain", 64'(out_valid), 64'd0);

        // sub / srai / lui back-to-back at full rate
        offer(32'h407302B3, 32'h44);
        step();
        check_bundle("sub", ALU_SUB, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("sub.rd", 64'(out_rd), 64'd5);
        offer(32'h40315093, 32'h48);
        step();
        check_bundle("srai", ALU_SRA, 1'b0, 1'b1, 32'h3, 1'b1, 1'b0);
        check("srai.rs1", 64'(out_rs1), 64'd2);
        offer(32'h12345537, 32'h4C);
        step();
        in_valid = 1'b0;
        check_bundle("lui", ALU_B, 1'b0, 1'b1, 32'h12345000, 1'b1, 1'b0);
        check("lui.rd", 64'(out_rd), 64'd10);
        step();
        check("b2b.drain", 64'(out_valid), 64'd0);

        // beq x0,x0,-4 ; jal x1,+8 ; illegal and rd=0 corners
        offer(32'hFE000EE3, 32'h100);
        step();
        check_bundle("beq", ALU_ADD, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
        check("beq.pc", 64'(out_pc), 64'h100);
        offer(32'h008000EF, 32'h104);
        step();
        check_bundle("jal", ALU_ADD, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0);
        offer(32'h00000000, 32'h108);
        step();
        check_bundle("zero", ALU_ADD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        offer(32'h00000033, 32'h10C);
        step();
        check_bundle("add_x0", ALU_ADD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        offer(32'h4020C1B3, 32'h110);
        step();
        in_valid = 1'b0;
        check_bundle("op_f7bad", ALU_ADD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();

        // Backpressure: addi x1..x3 immediates 1,2,3 identify I0..I2
        out_ready = 1'b0;
        offer(32'h00100093, 32'h200);
        step();
        check("bp.i0_valid", 64'(out_valid), 64'd1);
        check("bp.i0_ready", 64'(in_ready),  64'd1);
        offer(32'h00200113, 32'h204);
        step();
        check("bp.skid_ready", 64'(in_ready), 64'd0);
        check("bp.hold_imm",   64'(out_imm),  64'd1);
        offer(32'h00300193, 32'h208);
        step();
        step();
        check("bp.stall_ready", 64'(in_ready), 64'd0);
        check("bp.stall_imm",   64'(out_imm),  64'd1);
        check("bp.stall_pc",    64'(out_pc),   64'h200);
        out_ready = 1'b1;
        step();
        check("bp.i1_imm",   64'(out_imm),   64'd2);
        check("bp.i1_valid", 64'(out_valid), 64'd1);
        check("bp.i1_ready", 64'(in_ready),  64'd1);
        step();
        in_valid = 1'b0;
        check("bp.i2_imm",   64'(out_imm),   64'd3);
        check("bp.i2_pc",    64'(out_pc),    64'h208);
        step();
        check("bp.drain", 64'(out_valid), 64'd0);

        // Flush with both entries full and an instruction offered
        out_ready = 1'b0;
        offer(32'h00100093, 32'h300);
        step();
        offer(32'h00200113, 32'h304);
        step();
        offer(32'h00300193, 32'h308);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1.out_valid", 64'(out_valid), 64'd0);
        check("fl1.in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        step();
        check("fl1.nothing", 64'(out_valid), 64'd0);

        // Flush while in_ready=1: the instruction accepted that cycle is dropped
        out_ready = 1'b0;
        offer(32'h00100093, 32'h400);
        step();
        offer(32'h00200113, 32'h404);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl2.out_valid", 64'(out_valid), 64'd0);
        check("fl2.in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        step();
        check("fl2.nothing", 64'(out_valid), 64'd0);

        // Reset pulsed mid-cycle with both entries full
        out_ready = 1'b0;
        offer(32'h00100093, 32'h500);
        step();
        offer(32'h00200113, 32'h504);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mrst.out_valid", 64'(out_valid), 64'd0);
        check("mrst.in_ready",  64'(in_ready),  64'd1);
        check("mrst.imm",       64'(out_imm),   64'd0);
        check("mrst.pc",        64'(out_pc),    64'd0);
        check("mrst.rd",        64'(out_rd),    64'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        offer(32'h00300193, 32'h508);
        step();
        in_valid = 1'b0;
        check("mrst.first_valid", 64'(out_valid), 64'd1);
        check("mrst.first_imm",   64'(out_imm),   64'd3);
        step();
        check("mrst.drain", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
